wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the in-order RV64 pipeline, sitting directly upstream of the register file. It accepts retiring instructions from the memory stage over a valid/ready handshake and waits for load responses. It aligns and sign- or zero-extends load data, then drives the register-file write port (RdWriteData/RdWriteAddr/RdWriteEnable) for exactly one cycle per instruction. It also handles pipeline flushes of loads still in flight.

## Interface
- DATA_W, 64, data path width
- ADDR_W, 5, register address width
- Clk  input  1  clock, all state updates on posedge
- Rst  input  1  asynchronous, active-low reset
- MemValid  input  1  memory stage presents an instruction
- MemReady  output  1  stage accepts this cycle
- MemRdAddr  input  ADDR_W  destination register
- MemRdWen  input  1  instruction writes rd
- MemAluResult  input  DATA_W  result for non-load instructions
- MemIsLoad  input  1  instruction is a load
- MemLoadFunct3  input  3  load type
- MemAddrLow  input  3  byte offset of load address
- LoadRespValid  input  1  load data returned this cycle
- LoadRespData  input  DATA_W  raw 8-byte-aligned doubleword
- Flush  input  1  kill in-flight load, block acceptance
- RdWriteData  output  DATA_W  register-file write data
- RdWriteAddr  output  ADDR_W  register-file write address
- RdWriteEnable  output  1  register-file write strobe

## Operation
- States: IDLE, COMMIT, WAIT_LOAD, DRAIN.
- Accept = MemValid && MemReady.
- MemReady = (state is IDLE or COMMIT) && !Flush.
- IDLE/COMMIT:
  - accept non-load -> capture MemAluResult, rd, wen; go to COMMIT.
  - accept load -> capture funct3, offset, rd, wen; go to WAIT_LOAD.
  - no accept -> IDLE.
- WAIT_LOAD:
  - Flush (with or without a same-cycle LoadRespValid) -> drop the entry. Go to IDLE if the response arrived that cycle, else DRAIN.
  - LoadRespValid without Flush -> register the extracted data; go to COMMIT.
- DRAIN: LoadRespValid -> discard data, go to IDLE. Flush is ignored here.
- Responses arriving in IDLE or COMMIT are ignored.
- In COMMIT an instruction already past the flush point is never flushed; its write always occurs.
- RdWriteEnable = (state == COMMIT) && captured wen && captured rd != 0.
- RdWriteAddr and RdWriteData hold the captured values and are stable for the whole COMMIT cycle.
- Load extraction, byte offset o = MemAddrLow:
  - 000 LB: byte o, sign-extend.
  - 001 LH: halfword o[2:1], sign-extend.
  - 010 LW: word o[2], sign-extend.
  - 011 LD: full doubleword.
  - 100 LBU, 101 LHU, 110 LWU: as LB, LH, LW but zero-extend.
  - 111: treated as LD.
  - Unused low offset bits are ignored (address aligned down).

## Timing
- Reset: state IDLE; RdWriteData = 0, RdWriteAddr = 0, RdWriteEnable = 0; MemReady = 1 after reset deasserts (when Flush low).
- Reset mid-operation: any captured entry is discarded; a later stray response lands in IDLE and is ignored.
- Non-load latency: accepted at edge n -> RdWriteEnable high during cycle n+1.
- Load latency: response at edge m -> write during cycle m+1.
- Back-to-back throughput: one non-load per cycle (COMMIT accepts the next instruction while writing the current one).
- No combinational path from LoadRespData to RdWriteData; all outputs except MemReady are registered.

## Configuration
- WB_COMMIT_CNT_EN defined: adds output CommitCount (64 bits), reset to 0.
  - Increments by 1 on every COMMIT cycle, including wen=0 and rd=x0 instructions.
  - Flushed or drained loads are not counted.
  - Wraps modulo 2^64.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- ADD retiring to rd=x5, MemAluResult=0x1234 -> next cycle RdWriteEnable=1, addr 5, data 0x1234; MemReady stays 1.
- LB, offset 3, response 0x0000_0000_8000_0000 -> one cycle after the response, data 0xFFFF_FFFF_FFFF_FF80.
- Same response via LBU -> data 0x80.
- LWU, offset 4, response 0xDEAD_BEEF_0000_0000 -> data 0x0000_0000_DEAD_BEEF.
- Load in WAIT_LOAD, Flush pulsed, response two cycles later -> no write; MemReady=0 until the response, then IDLE.
  - With WB_COMMIT_CNT_EN, CommitCount is unchanged.
- Non-load to rd=x0 -> RdWriteEnable stays 0; CommitCount increments by 1.
- Rst asserted while in WAIT_LOAD -> outputs 0, state IDLE; a subsequent response produces no write.

Source files
------------

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - memory-stage, load-response and register-file write signals of wb_stage
interface wb_stage_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
);
   logic              MemValid;
   logic              MemReady;
   logic [ADDR_W-1:0] MemRdAddr;
   logic              MemRdWen;
   logic [DATA_W-1:0] MemAluResult;
   logic              MemIsLoad;
   logic [2:0]        MemLoadFunct3;
   logic [2:0]        MemAddrLow;
   logic              LoadRespValid;
   logic [DATA_W-1:0] LoadRespData;
   logic              Flush;
   logic [DATA_W-1:0] RdWriteData;
   logic [ADDR_W-1:0] RdWriteAddr;
   logic              RdWriteEnable;

   modport master (
      output MemValid, MemRdAddr, MemRdWen, MemAluResult, MemIsLoad, MemLoadFunct3,
             MemAddrLow, LoadRespValid, LoadRespData, Flush,
      input  MemReady, RdWriteData, RdWriteAddr, RdWriteEnable
   );

   modport slave (
      input  MemValid, MemRdAddr, MemRdWen, MemAluResult, MemIsLoad, MemLoadFunct3,
             MemAddrLow, LoadRespValid, LoadRespData, Flush,
      output MemReady, RdWriteData, RdWriteAddr, RdWriteEnable
   );
endinterface

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RV64 write-back stage: load alignment/extension, flush handling, regfile write
// Optional commit counter output CommitCount enabled by defining WB_COMMIT_CNT_EN.
module wb_stage #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
) (
   input  logic      Clk,
   input  logic      Rst,
   wb_stage_if.slave bus
`ifdef WB_COMMIT_CNT_EN
   ,
   output logic [63:0] CommitCount
`endif
);

   typedef enum logic [1:0] {IDLE, COMMIT, WAIT_LOAD, DRAIN} state_t;

   state_t            state, state_n;
   logic [ADDR_W-1:0] rd_q, rd_n;
   logic              wen_q, wen_n;
   logic [DATA_W-1:0] data_q, data_n;
   logic [2:0]        funct3_q, funct3_n;
   logic [2:0]        off_q, off_n;
   logic              en_q, en_n;
   logic              mem_ready;

   // Offsets below the access size are ignored, so the lane index is the aligned-down offset.
   function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] raw,
                                                 input logic [2:0] funct3,
                                                 input logic [2:0] off);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] w;
      b = raw[{off, 3'b000} +: 8];
      h = raw[{off[2:1], 4'b0000} +: 16];
      w = raw[{off[2], 5'b00000} +: 32];
      case (funct3)
         3'b000:  extract = {{(DATA_W-8){b[7]}}, b};
         3'b001:  extract = {{(DATA_W-16){h[15]}}, h};
         3'b010:  extract = {{(DATA_W-32){w[31]}}, w};
         3'b100:  extract = {{(DATA_W-8){1'b0}}, b};
         3'b101:  extract = {{(DATA_W-16){1'b0}}, h};
         3'b110:  extract = {{(DATA_W-32){1'b0}}, w};
         default: extract = raw;
      endcase
   endfunction

   always_comb begin
      state_n   = state;
      mem_ready = 1'b0;
      rd_n      = rd_q;
      wen_n     = wen_q;
      data_n    = data_q;
      funct3_n  = funct3_q;
      off_n     = off_q;
      case (state)
         IDLE, COMMIT: begin
            mem_ready = !bus.Flush;
            state_n   = IDLE;
            if (bus.MemValid && mem_ready) begin
               rd_n  = bus.MemRdAddr;
               wen_n = bus.MemRdWen;
               if (bus.MemIsLoad) begin
                  funct3_n = bus.MemLoadFunct3;
                  off_n    = bus.MemAddrLow;
                  state_n  = WAIT_LOAD;
               end else begin
                  data_n  = bus.MemAluResult;
                  state_n = COMMIT;
               end
            end
         end
         WAIT_LOAD: begin
            if (bus.Flush) begin
               state_n = bus.LoadRespValid ? IDLE : DRAIN;
            end else if (bus.LoadRespValid) begin
               data_n  = extract(bus.LoadRespData, funct3_q, off_q);
               state_n = COMMIT;
            end
         end
         DRAIN: begin
            if (bus.LoadRespValid) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      // Strobe is decided a cycle early so it comes straight from a flop during COMMIT.
      en_n = (state_n == COMMIT) && wen_n && (rd_n != '0);
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state    <= IDLE;
         rd_q     <= '0;
         wen_q    <= 1'b0;
         data_q   <= '0;
         funct3_q <= 3'b000;
         off_q    <= 3'b000;
         en_q     <= 1'b0;
      end else begin
         state    <= state_n;
         rd_q     <= rd_n;
         wen_q    <= wen_n;
         data_q   <= data_n;
         funct3_q <= funct3_n;
         off_q    <= off_n;
         en_q     <= en_n;
      end
   end

   assign bus.MemReady      = mem_ready;
   assign bus.RdWriteData   = data_q;
   assign bus.RdWriteAddr   = rd_q;
   assign bus.RdWriteEnable = en_q;

`ifdef WB_COMMIT_CNT_EN
   logic [63:0] commit_cnt;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)                 commit_cnt <= '0;
      else if (state == COMMIT) commit_cnt <= commit_cnt + 64'd1;
   end

   assign CommitCount = commit_cnt;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage register-file writes, loads and flushes
module tb_wb_stage;

   typedef struct {
      logic [4:0]  addr;
      logic [63:0] data;
   } wr_t;

   logic Clk;
   logic Rst;
   wr_t  sb[$];
   int   errors = 0;
   int   checks = 0;

   wb_stage_if #(.DATA_W(64), .ADDR_W(5)) bus ();

`ifdef WB_COMMIT_CNT_EN
   logic [63:0] commit_count;
   logic [63:0] c0;
   wb_stage dut (.Clk(Clk), .Rst(Rst), .bus(bus), .CommitCount(commit_count));
`else
   wb_stage dut (.Clk(Clk), .Rst(Rst), .bus(bus));
`endif

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference extraction assembled byte by byte from the aligned-down base.
   function automatic logic [63:0] model(input logic [63:0] raw, input logic [2:0] f3,
                                         input logic [2:0] off);
      int          n;
      int          o;
      int          base;
      logic [63:0] r;
      case (f3[1:0])
         2'd0:    n = 1;
         2'd1:    n = 2;
         2'd2:    n = 4;
         default: n = 8;
      endcase
      o    = int'(off);
      base = o - (o % n);
      r    = '0;
      for (int i = 0; i < n; i++) r[8*i +: 8] = raw[8*(base+i) +: 8];
      if (!f3[2] && n < 8 && r[8*n-1])
         for (int i = 8*n; i < 64; i++) r[i] = 1'b1;
      return r;
   endfunction

   initial begin
      wr_t e;
      forever begin
         @(negedge Clk);
         if (bus.RdWriteEnable === 1'b1) begin
            if (sb.size() == 0) begin
               check("unexpected_write", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               check("wr_addr", 64'(bus.RdWriteAddr), 64'(e.addr));
               check("wr_data", bus.RdWriteData, e.data);
            end
         end
      end
   end

   task automatic idle();
      bus.MemValid  = 1'b0;
      bus.MemIsLoad = 1'b0;
   endtask

   task automatic alu(input logic [4:0] rd, input logic wen, input logic [63:0] val);
      bus.MemValid     = 1'b1;
      bus.MemIsLoad    = 1'b0;
      bus.MemRdAddr    = rd;
      bus.MemRdWen     = wen;
      bus.MemAluResult = val;
      if (wen && rd != 5'd0) sb.push_back('{rd, val});
      @(negedge Clk);
      check("alu_ready", 64'(bus.MemReady), 64'd1);
      @(posedge Clk); #1;
   endtask

   task automatic issue_load(input logic [4:0] rd, input logic [2:0] f3, input logic [2:0] off);
      bus.MemValid      = 1'b1;
      bus.MemIsLoad     = 1'b1;
      bus.MemRdAddr     = rd;
      bus.MemRdWen      = 1'b1;
      bus.MemLoadFunct3 = f3;
      bus.MemAddrLow    = off;
      @(posedge Clk); #1;
      idle();
   endtask

   task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [2:0] off,
                       input logic [63:0] raw, input logic [63:0] exp, input int gap);
      issue_load(rd, f3, off);
      repeat (gap) begin
         @(negedge Clk);
         check("ld_wait_ready", 64'(bus.MemReady), 64'd0);
         @(posedge Clk); #1;
      end
      bus.LoadRespValid = 1'b1;
      bus.LoadRespData  = raw;
      if (rd != 5'd0) sb.push_back('{rd, exp});
      @(posedge Clk); #1;
      bus.LoadRespValid = 1'b0;
      @(negedge Clk);
      check("ld_en", 64'(bus.RdWriteEnable), 64'(rd != 5'd0));
      @(posedge Clk); #1;
   endtask

   initial begin
      logic [63:0] raw;
      logic [2:0]  f3;
      logic [2:0]  off;
      logic [4:0]  rd;

      Rst = 1'b0;
      bus.MemValid = 1'b0;      bus.MemRdAddr = '0;        bus.MemRdWen = 1'b0;
      bus.MemAluResult = '0;    bus.MemIsLoad = 1'b0;      bus.MemLoadFunct3 = '0;
      bus.MemAddrLow = '0;      bus.LoadRespValid = 1'b0;  bus.LoadRespData = '0;
      bus.Flush = 1'b0;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      check("rst_en", 64'(bus.RdWriteEnable), 64'd0);
      check("rst_addr", 64'(bus.RdWriteAddr), 64'd0);
      check("rst_data", bus.RdWriteData, 64'd0);
`ifdef WB_COMMIT_CNT_EN
      check("rst_count", commit_count, 64'd0);
`endif
      @(posedge Clk); #1;
      Rst = 1'b1;
      @(negedge Clk);
      check("rst_ready", 64'(bus.MemReady), 64'd1);
      @(posedge Clk); #1;

      alu(5'd5, 1'b1, 64'h1234);
      idle();
      @(negedge Clk);
      check("add_en", 64'(bus.RdWriteEnable), 64'd1);
      check("add_addr", 64'(bus.RdWriteAddr), 64'd5);
      check("add_data", bus.RdWriteData, 64'h1234);
      check("add_ready", 64'(bus.MemReady), 64'd1);
      @(posedge Clk); #1;

      load(5'd1, 3'b000, 3'd3, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 1);
      load(5'd2, 3'b100, 3'd3, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080, 0);
      load(5'd3, 3'b110, 3'd4, 64'hDEAD_BEEF_0000_0000, 64'h0000_0000_DEAD_BEEF, 2);
      load(5'd4, 3'b001, 3'd3, 64'h8877_6655_4433_2211, 64'h0000_0000_0000_4433, 0);
      load(5'd6, 3'b001, 3'd6, 64'h8877_6655_4433_2211, 64'hFFFF_FFFF_FFFF_8877, 1);
      load(5'd8, 3'b010, 3'd5, 64'h8877_6655_4433_2211, 64'hFFFF_FFFF_8877_6655, 0);
      load(5'd10, 3'b101, 3'd7, 64'h8877_6655_4433_2211, 64'h0000_0000_0000_8877, 0);
      load(5'd11, 3'b111, 3'd5, 64'h8877_6655_4433_2211, 64'h8877_6655_4433_2211, 0);
      load(5'd12, 3'b011, 3'd1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1);

      for (int i = 0; i < 10; i++) begin
         rd  = 5'($urandom_range(1, 31));
         f3  = 3'($urandom_range(0, 7));
         off = 3'($urandom_range(0, 7));
         raw = {$urandom, $urandom};
         load(rd, f3, off, raw, model(raw, f3, off), int'($urandom_range(0, 2)));
      end

`ifdef WB_COMMIT_CNT_EN
      c0 = commit_count;
`endif
      alu(5'd13, 1'b1, 64'hAAAA_0001);
      alu(5'd14, 1'b1, 64'hAAAA_0002);
      alu(5'd15, 1'b1, 64'hAAAA_0003);
      idle();
      @(negedge Clk);
      check("b2b_last_en", 64'(bus.RdWriteEnable), 64'd1);
      @(posedge Clk); #1;
`ifdef WB_COMMIT_CNT_EN
      @(negedge Clk);
      check("b2b_count", commit_count, c0 + 64'd3);
      @(posedge Clk); #1;
`endif

      issue_load(5'd7, 3'b011, 3'd0);
`ifdef WB_COMMIT_CNT_EN
      c0 = commit_count;
`endif
      @(negedge Clk);
      check("fl_wait_ready", 64'(bus.MemReady), 64'd0);
      @(posedge Clk); #1;
      bus.Flush = 1'b1;
      @(negedge Clk);
      check("fl_ready", 64'(bus.MemReady), 64'd0);
      @(posedge Clk); #1;
      bus.Flush = 1'b0;
      @(negedge Clk);
      check("drain_ready", 64'(bus.MemReady), 64'd0);
      @(posedge Clk); #1;
      bus.Flush = 1'b1;
      @(negedge Clk);
      check("drain_ready2", 64'(bus.MemReady), 64'd0);
      @(posedge Clk); #1;
      bus.Flush = 1'b0;
      bus.LoadRespValid = 1'b1;
      bus.LoadRespData  = 64'hFEED_FACE_CAFE_BEEF;
      @(posedge Clk); #1;
      bus.LoadRespValid = 1'b0;
      @(negedge Clk);
      check("drain_no_wr", 64'(bus.RdWriteEnable), 64'd0);
      check("drain_idle_ready", 64'(bus.MemReady), 64'd1);
`ifdef WB_COMMIT_CNT_EN
      check("flush_count", commit_count, c0);
`endif
      @(posedge Clk); #1;

      issue_load(5'd9, 3'b000, 3'd0);
      bus.Flush = 1'b1;
      bus.LoadRespValid = 1'b1;
      @(posedge Clk); #1;
      bus.Flush = 1'b0;
      bus.LoadRespValid = 1'b0;
      @(negedge Clk);
      check("flresp_ready", 64'(bus.MemReady), 64'd1);
      check("flresp_no_wr", 64'(bus.RdWriteEnable), 64'd0);
      @(posedge Clk); #1;

      bus.LoadRespValid = 1'b1;
      @(posedge Clk); #1;
      bus.LoadRespValid = 1'b0;
      @(negedge Clk);
      check("stray_no_wr", 64'(bus.RdWriteEnable), 64'd0);
      @(posedge Clk); #1;

      bus.Flush = 1'b1;
      bus.MemValid = 1'b1;
      bus.MemRdAddr = 5'd20;
      bus.MemRdWen = 1'b1;
      @(negedge Clk);
      check("idle_flush_ready", 64'(bus.MemReady), 64'd0);
      @(posedge Clk); #1;
      bus.Flush = 1'b0;
      idle();
      @(negedge Clk);
      check("idle_flush_no_wr", 64'(bus.RdWriteEnable), 64'd0);
      @(posedge Clk); #1;

      alu(5'd21, 1'b1, 64'h5555_0000_0000_0021);
      idle();
      bus.Flush = 1'b1;
      @(negedge Clk);
      check("commit_flush_en", 64'(bus.RdWriteEnable), 64'd1);
      @(posedge Clk); #1;
      bus.Flush = 1'b0;

`ifdef WB_COMMIT_CNT_EN
      c0 = commit_count;
`endif
      alu(5'd0, 1'b1, 64'hAAAA);
      idle();
      @(negedge Clk);
      check("x0_no_wr", 64'(bus.RdWriteEnable), 64'd0);
      @(posedge Clk); #1;
      alu(5'd3, 1'b0, 64'hBBBB);
      idle();
      @(negedge Clk);
      check("nowen_no_wr", 64'(bus.RdWriteEnable), 64'd0);
      @(posedge Clk); #1;
`ifdef WB_COMMIT_CNT_EN
      @(negedge Clk);
      check("x0_count", commit_count, c0 + 64'd2);
      @(posedge Clk); #1;
`endif

      issue_load(5'd4, 3'b011, 3'd0);
      #2;
      Rst = 1'b0;
      #1;
      check("mid_rst_en", 64'(bus.RdWriteEnable), 64'd0);
      check("mid_rst_addr", 64'(bus.RdWriteAddr), 64'd0);
      check("mid_rst_data", bus.RdWriteData, 64'd0);
`ifdef WB_COMMIT_CNT_EN
      check("mid_rst_count", commit_count, 64'd0);
`endif
      @(posedge Clk); #1;
      Rst = 1'b1;
      bus.LoadRespValid = 1'b1;
      bus.LoadRespData  = 64'h1111_2222_3333_4444;
      @(posedge Clk); #1;
      bus.LoadRespValid = 1'b0;
      @(negedge Clk);
      check("post_rst_no_wr", 64'(bus.RdWriteEnable), 64'd0);
      check("post_rst_ready", 64'(bus.MemReady), 64'd1);

      repeat (3) @(posedge Clk);
      #1;
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
